// File: rtl/data_mem_access.sv
// Data-memory access stage: launches one REQ/ACK transaction per request
// level from the control FSM, aligns byte lanes for stores, extracts and
// extends load data, and stalls control until the access resolves.
module data_mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  BE,
    input  logic [2:0]  funct3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        DONE,
    output logic        ERR,
    output logic        STALL,
    output logic        D_REQ,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic [31:0] D_RDATA,
    input  logic        D_ACK
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    // Last counter value tolerated before an unacknowledged request aborts.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        arm_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;
    logic        d_req_q;
    logic        d_we_q;
    logic [31:0] d_addr_q;
    logic [3:0]  d_be_q;
    logic [31:0] d_wdata_q;

    logic        launch;
    logic        conflict;
    logic        misalign;
    logic [6:0]  be_shift;
    logic [31:0] lane;
    logic [31:0] rdata_d;

    // Launch decode, launch-time checks and load-data extraction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        rdata_d  = 32'h0;
        launch   = (state_q == ST_IDLE) && arm_q && (MemRead || MemWrite);
        conflict = MemRead && MemWrite;
        be_shift = {3'b000, BE} << ADDR[1:0];
        misalign = |be_shift[6:4];
        lane     = D_RDATA >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  rdata_d = {{24{lane[7]}}, lane[7:0]};
            3'b001:  rdata_d = {{16{lane[15]}}, lane[15:0]};
            3'b100:  rdata_d = {24'h0, lane[7:0]};
            3'b101:  rdata_d = {16'h0, lane[15:0]};
            default: rdata_d = D_RDATA;
        endcase
    end

    // Control FSM with registered memory-side and result outputs.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'h0;
            arm_q     <= 1'b1;
            off_q     <= 2'b00;
            funct3_q  <= 3'b000;
            rdata_q   <= 32'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            d_req_q   <= 1'b0;
            d_we_q    <= 1'b0;
            d_addr_q  <= 32'h0;
            d_be_q    <= 4'h0;
            d_wdata_q <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // A held request level launches once; re-arm only after it drops.
            if (launch) begin
                arm_q <= 1'b0;
            end else if (!MemRead && !MemWrite) begin
                arm_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        if (conflict || misalign) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            cnt_q     <= 8'h0;
                            d_req_q   <= 1'b1;
                            d_we_q    <= MemWrite;
                            d_addr_q  <= {ADDR[31:2], 2'b00};
                            d_be_q    <= be_shift[3:0];
                            d_wdata_q <= WDATA << {ADDR[1:0], 3'b000};
                            off_q     <= ADDR[1:0];
                            funct3_q  <= funct3;
                        end
                    end
                end
                ST_REQ: begin
                    if (D_ACK) begin
                        state_q <= ST_DONE;
                        d_req_q <= 1'b0;
                        done_q  <= 1'b1;
                        if (!d_we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= ST_IDLE;
                        d_req_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign STALL   = launch || (state_q == ST_REQ);
    assign RDATA   = rdata_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign D_REQ   = d_req_q;
    assign D_WE    = d_we_q;
    assign D_ADDR  = d_addr_q;
    assign D_BE    = d_be_q;
    assign D_WDATA = d_wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: expected completions are queued
// when an access is driven and compared when DONE or ERR appears.
module tb_data_mem_access;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  BE;
    logic [2:0]  funct3;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        DONE;
    logic        ERR;
    logic        STALL;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [3:0]  D_BE;
    logic [31:0] D_WDATA;
    logic [31:0] D_RDATA;
    logic        D_ACK;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_cnt  = 0;
    logic        req_prev = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    data_mem_access #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .MemRead(MemRead), .MemWrite(MemWrite),
        .BE(BE), .funct3(funct3), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA), .DONE(DONE), .ERR(ERR), .STALL(STALL),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE),
        .D_WDATA(D_WDATA), .D_RDATA(D_RDATA), .D_ACK(D_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: counts request launches and scores every pulse.
    always @(negedge CLK) begin
        if (D_REQ === 1'b1 && req_prev !== 1'b1) req_cnt++;
        req_prev = D_REQ;
        if (DONE === 1'b1 || ERR === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'h0, DONE, ERR}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'h0, DONE, ERR}, e.is_err ? 32'h1 : 32'h2);
                check("pulse_rdata", RDATA, e.rdata);
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 6 && sb.size() != 0; i++) @(negedge CLK);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    // One access with a memory responder acknowledging after lat REQ cycles.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] mem_word,
                          input bit exp_err, input logic [3:0] exp_dbe,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int   req_before;
        exp_t e;
        req_before = req_cnt;
        @(posedge CLK); #1;
        MemRead = rd; MemWrite = wr; BE = be; funct3 = f3; ADDR = addr; WDATA = wdata;
        e.is_err = exp_err;
        e.rdata  = exp_rdata;
        sb.push_back(e);
        @(negedge CLK);
        check({tag, "_stall_launch"}, STALL, 1);
        @(posedge CLK); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge CLK);
        if (exp_err) begin
            check({tag, "_err"}, ERR, 1);
            check({tag, "_no_req"}, req_cnt - req_before, 0);
        end else begin
            check({tag, "_d_req"}, D_REQ, 1);
            check({tag, "_d_addr"}, D_ADDR, {addr[31:2], 2'b00});
            check({tag, "_d_be"}, D_BE, exp_dbe);
            check({tag, "_d_we"}, D_WE, wr);
            if (wr) check({tag, "_d_wdata"}, D_WDATA, exp_wdata);
            check({tag, "_stall_req"}, STALL, 1);
            for (int i = 0; i < lat; i++) begin
                @(negedge CLK);
                check({tag, "_stall_wait"}, STALL, 1);
            end
            D_ACK = 1'b1; D_RDATA = mem_word;
            @(posedge CLK); #1;
            D_ACK = 1'b0; D_RDATA = 32'h0;
            @(negedge CLK);
            check({tag, "_done"}, DONE, 1);
            check({tag, "_stall_done"}, STALL, 0);
            check({tag, "_req_dropped"}, D_REQ, 0);
            check({tag, "_one_req"}, req_cnt - req_before, 1);
        end
        drain(tag);
        last_rdata = exp_rdata;
    endtask

    initial begin
        exp_t e;
        int   req_before;
        int   high;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   req_before;
        int   high;
        RSTn = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; BE = 4'h0; funct3 = 3'b000;
        ADDR = 32'h0; WDATA = 32'h0; D_RDATA = 32'h0; D_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_outputs", {RDATA, 28'h0, DONE, ERR, STALL, D_REQ}, 64'h0);
        check("rst_d_we", D_WE, 0);
        check("rst_d_addr", D_ADDR, 0);
        check("rst_d_be", D_BE, 0);
        check("rst_d_wdata", D_WDATA, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;

        // Loads, including ACK on the last cycle before timeout would fire.
        access("lw",  1, 0, 4'b1111, 3'b010, 32'h100, 0, 3, 32'hDEADBEEF, 0, 4'b1111, 0, 32'hDEADBEEF);
        access("lb",  1, 0, 4'b0001, 3'b000, 32'h103, 0, 0, 32'h80FF0000, 0, 4'b1000, 0, 32'hFFFFFF80);
        access("lbu", 1, 0, 4'b0001, 3'b100, 32'h103, 0, 0, 32'h80FF0000, 0, 4'b1000, 0, 32'h00000080);
        access("lh",  1, 0, 4'b0011, 3'b001, 32'h102, 0, 1, 32'h80011234, 0, 4'b1100, 0, 32'hFFFF8001);
        access("lhu", 1, 0, 4'b0011, 3'b101, 32'h102, 0, 0, 32'h80011234, 0, 4'b1100, 0, 32'h00008001);
        access("lw011", 1, 0, 4'b1111, 3'b011, 32'h104, 0, 2, 32'h13579BDF, 0, 4'b1111, 0, 32'h13579BDF);

        // Stores leave RDATA unchanged.
        access("sh", 0, 1, 4'b0011, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 0, 4'b1100, 32'hABCD0000, last_rdata);
        access("sb", 0, 1, 4'b0001, 3'b000, 32'h301, 32'h0000005A, 1, 0, 0, 4'b0010, 32'h00005A00, last_rdata);

        // Launch-time errors.
        access("mis_lw", 1, 0, 4'b1111, 3'b010, 32'h101, 0, 0, 0, 1, 0, 0, last_rdata);
        access("mis_sh", 0, 1, 4'b0011, 3'b001, 32'h203, 32'h1234, 0, 0, 1, 0, 0, last_rdata);
        access("conflict", 1, 1, 4'b1111, 3'b010, 32'h100, 0, 0, 0, 1, 0, 0, last_rdata);

        // Held MemRead launches exactly one access.
        req_before = req_cnt;
        @(posedge CLK); #1;
        MemRead = 1'b1; BE = 4'b1111; funct3 = 3'b010; ADDR = 32'h400;
        e.is_err = 0; e.rdata = 32'h12345678; sb.push_back(e);
        @(posedge CLK); #1;
        D_ACK = 1'b1; D_RDATA = 32'h12345678;
        @(posedge CLK); #1;
        D_ACK = 1'b0; D_RDATA = 32'h0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        check("hold_stall", STALL, 0);
        @(posedge CLK); #1;
        MemRead = 1'b0;
        repeat (2) @(posedge CLK);
        check("hold_one_req", req_cnt - req_before, 1);
        drain("hold");
        last_rdata = 32'h12345678;

        // Timeout: D_REQ stays high for TIMEOUT cycles, then ERR.
        @(posedge CLK); #1;
        MemRead = 1'b1; ADDR = 32'h500;
        e.is_err = 1; e.rdata = last_rdata; sb.push_back(e);
        @(posedge CLK); #1;
        MemRead = 1'b0;
        high = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (D_REQ !== 1'b1) break;
            high++;
        end
        check("to_req_cycles", high, 4);
        check("to_err", ERR, 1);
        check("to_stall", STALL, 0);
        check("to_rdata", RDATA, last_rdata);
        drain("to");

        // Reset in the second REQ cycle, then a stray ACK.
        req_before = req_cnt;
        @(posedge CLK); #1;
        MemRead = 1'b1; ADDR = 32'h600;
        @(posedge CLK); #1;
        MemRead = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(negedge CLK);
        check("rstmid_d_req", D_REQ, 0);
        check("rstmid_rdata", RDATA, 0);
        D_ACK = 1'b1; D_RDATA = 32'hFFFFFFFF;
        @(posedge CLK); #1;
        D_ACK = 1'b0; D_RDATA = 32'h0;
        repeat (3) @(negedge CLK);
        check("rstmid_quiet", {30'h0, DONE, ERR}, 0);
        check("rstmid_rdata_after", RDATA, 0);
        check("rstmid_one_req", req_cnt - req_before, 1);
        last_rdata = 32'h0;

        // Recovery after reset.
        access("lw_after_rst", 1, 0, 4'b1111, 3'b010, 32'h700, 0, 1, 32'hCAFEF00D, 0, 4'b1111, 0, 32'hCAFEF00D);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Data-memory access stage directly downstream of the multi-cycle control FSM. It consumes MemRead/MemWrite/BE/funct3 plus the ALU address and store data.
- It drives a variable-latency data memory over a REQ/ACK handshake, aligns byte lanes, and sign/zero-extends load data for the writeback mux.
- It stalls the control FSM until the access completes, and flags misaligned accesses, read/write conflicts and memory timeouts.

Parameters:
- TIMEOUT, 16, max cycles D_REQ may stay high without D_ACK before the access aborts (range 1..255).

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RSTn  input  1  synchronous active-low reset
- MemRead  input  1  load request level from control
- MemWrite  input  1  store request level from control
- BE  input  4  unshifted byte enable from control: 0001 byte, 0011 half, 1111 word
- funct3  input  3  load/store width and signedness (bit 2 = unsigned load)
- ADDR  input  32  byte address from ALU
- WDATA  input  32  store data, LSB-justified
- RDATA  output  32  aligned and extended load result; holds until next completed load
- DONE  output  1  one-cycle pulse when an access completes
- ERR  output  1  one-cycle pulse on misalign, conflict or timeout
- STALL  output  1  high while an access is pending
- D_REQ  output  1  memory request
- D_WE  output  1  1 = write
- D_ADDR  output  32  word address, {ADDR[31:2],2'b00}
- D_BE  output  4  BE << ADDR[1:0]
- D_WDATA  output  32  WDATA << (8*ADDR[1:0])
- D_RDATA  input  32  memory read word, valid when D_ACK=1
- D_ACK  input  1  memory completion, single cycle

Behaviour:
- Reset (RSTn=0 at a rising edge): state IDLE; timeout counter 0; arm flag 1.
  - All outputs 0 (RDATA=0, DONE=0, ERR=0, STALL=0, D_REQ=0, D_WE=0, D_ADDR=0, D_BE=0, D_WDATA=0).
  - Reset mid-access drops D_REQ on that edge. No DONE or ERR is generated, and any later D_ACK is ignored.
- Launch condition: IDLE, arm=1, and (MemRead|MemWrite)=1.
  - Arm clears on launch and re-sets once MemRead=MemWrite=0 are sampled. A held request level therefore launches exactly one access.
- STALL is combinational: launch condition OR state==REQ.
- Checks at launch, evaluated in this priority order:
  - MemRead=1 and MemWrite=1: conflict. ERR pulses next cycle, no memory request, return to IDLE.
  - (BE << ADDR[1:0]) overflows 4 bits (half at offset 3; word at offset 1, 2 or 3): misalign. ERR pulses next cycle, no memory request.
  - Otherwise: go to REQ next cycle. D_REQ=1; D_WE=MemWrite; D_ADDR/D_BE/D_WDATA are registered from the launch-cycle inputs. Counter clears.
- REQ:
  - D_* outputs are held stable.
  - Counter increments each cycle D_ACK=0.
  - If D_ACK=1: go to DONE, D_REQ=0 next cycle.
    - On a load, RDATA is registered from D_RDATA: lane = D_RDATA >> (8*ADDR[1:0]).
    - funct3 000/001: sign-extend bit 7/15. funct3 100/101: zero-extend. 010: full word.
  - If counter reaches TIMEOUT-1 with D_ACK=0: go to IDLE, ERR pulses, D_REQ=0, RDATA unchanged.
- DONE: DONE=1 for exactly one cycle, STALL=0, then IDLE. No launch occurs from DONE. Stores leave RDATA unchanged.
- Minimum latency: launch at cycle N, D_REQ at N+1, D_ACK at N+1, DONE at N+2.
- D_ACK while not in REQ is ignored.
- funct3 values 011/110/111 on a load are treated as word.

Test Plan:
- Reset, then LW: ADDR=0x100, BE=1111, funct3=010, D_ACK 3 cycles after D_REQ with D_RDATA=0xDEADBEEF.
  - Required: D_ADDR=0x100, D_BE=1111, D_WE=0; STALL high throughout; RDATA=0xDEADBEEF with DONE one cycle after ACK.
- LB and LBU at ADDR=0x103 with D_RDATA=0x80FF_0000, immediate ACK.
  - Required: D_BE=1000; LB gives RDATA=0xFFFFFF80, LBU gives 0x00000080.
- SH at ADDR=0x202, WDATA=0x0000ABCD, BE=0011.
  - Required: D_BE=1100, D_WDATA=0xABCD0000, D_WE=1; DONE pulses; RDATA unchanged.
- Misalign and conflict:
  - LW at ADDR=0x101: ERR pulse, D_REQ never asserted.
  - MemRead=MemWrite=1: ERR pulse, no request.
  - MemRead held high 5 cycles after completion: exactly one access launched.
- Timeout with TIMEOUT=4, D_ACK tied 0: D_REQ high for exactly 4 cycles, then ERR pulse, STALL low, RDATA unchanged.
- Reset mid-access: RSTn=0 in second REQ cycle, then D_ACK=1.
  - Required: D_REQ=0 after that edge; no DONE, no ERR; RDATA=0.
